// File: rtl/trigger_csr_regs_pkg.sv
// Shared constants and tdata1 layout for the debug trigger CSR block.
package trigger_csr_regs_pkg;

    localparam logic [11:0] TSELECT_ADDR = 12'h7A0;
    localparam logic [11:0] TDATA1_ADDR  = 12'h7A1;
    localparam logic [11:0] TDATA2_ADDR  = 12'h7A2;
    localparam logic [11:0] TDATA3_ADDR  = 12'h7A3;
    localparam logic [11:0] TINFO_ADDR   = 12'h7A4;
    localparam logic [7:0]  TRIG_PAGE    = 8'h7A;

    localparam int TYPE_LSB   = 28;
    localparam int DMODE_BIT  = 27;
    localparam int HIT_BIT    = 20;
    localparam int ACTION_LSB = 12;
    localparam int CHAIN_BIT  = 11;

    localparam logic [3:0]  MCTRL_TYPE = 4'd2;
    localparam logic [31:0] TDATA1_RST = 32'h2000_0000;
    localparam logic [31:0] TINFO_VAL  = 32'h0000_0004;

    // hit, action[0], chain, m, execute, store, load survive a write as-is
    localparam logic [31:0] TDATA1_KEEP = 32'h0010_1847;

    typedef struct packed {
        logic [3:0] ttype;
        logic       dmode;
        logic [5:0] maskmax;
        logic       hit;
        logic       select;
        logic       timing;
        logic [1:0] sizelo;
        logic [3:0] action;
        logic       chain;
        logic [3:0] match;
        logic       m;
        logic [2:0] rsvd;
        logic       execute;
        logic       store;
        logic       load;
    } tdata1_t;

    function automatic tdata1_t legalise_tdata1(input logic [31:0] wr,
                                                input logic        cur_dmode,
                                                input logic        dbg_mode,
                                                input logic        last);
        logic [31:0] t;
        t = wr & TDATA1_KEEP;
        t[TYPE_LSB +: 4] = MCTRL_TYPE;
        t[DMODE_BIT]     = dbg_mode ? wr[DMODE_BIT] : cur_dmode;
        if (last) begin
            t[CHAIN_BIT] = 1'b0;
        end
        if (wr[TYPE_LSB +: 4] != MCTRL_TYPE) begin
            t = '0;
        end
        return tdata1_t'(t);
    endfunction

endpackage

// File: rtl/trigger_slot.sv
// One trigger's tdata1/2/3 with WARL legalisation, dmode protection and hit capture.
// Writes land on the next edge; ill_o is combinational and registered by the parent.
module trigger_slot
    import trigger_csr_regs_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter bit LAST       = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  dbg_mode_i,
    input  logic                  wr1_en_i,
    input  logic                  wr2_en_i,
    input  logic                  wr3_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  hw_hit_i,
    output logic [31:0]           tdata1_o,
    output logic [DATA_WIDTH-1:0] tdata2_o,
    output logic [DATA_WIDTH-1:0] tdata3_o,
    output logic                  ill_o
);

    tdata1_t               tdata1_q, tdata1_d;
    logic [DATA_WIDTH-1:0] tdata2_q, tdata2_d;
    logic [DATA_WIDTH-1:0] tdata3_q, tdata3_d;
    logic                  locked;

    // A debug-mode-owned trigger is read-only to machine-mode software
    assign locked = tdata1_q.dmode & ~dbg_mode_i;
    assign ill_o  = locked & (wr1_en_i | wr2_en_i | wr3_en_i);

    always_comb begin
        tdata1_d = tdata1_q;
        tdata2_d = tdata2_q;
        tdata3_d = tdata3_q;
        if (wr1_en_i && !locked) begin
            tdata1_d = legalise_tdata1(wr_data_i, tdata1_q.dmode, dbg_mode_i, LAST);
        end
        if (wr2_en_i && !locked) begin
            tdata2_d = wr_data_i;
        end
        if (wr3_en_i && !locked) begin
            tdata3_d = wr_data_i;
        end
        // Hardware hit is ORed after the software value so a clear cannot lose it
        if (tdata1_d.ttype == MCTRL_TYPE) begin
            tdata1_d.hit = tdata1_d.hit | hw_hit_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tdata1_q <= tdata1_t'(TDATA1_RST);
            tdata2_q <= '0;
            tdata3_q <= '0;
        end else begin
            tdata1_q <= tdata1_d;
            tdata2_q <= tdata2_d;
            tdata3_q <= tdata3_d;
        end
    end

    assign tdata1_o = tdata1_q;
    assign tdata2_o = tdata2_q;
    assign tdata3_o = tdata3_q;

endmodule

// File: rtl/trigger_csr_regs.sv
// Debug trigger CSR file: tselect, address decode and the 1-cycle registered read path.
// Writes are visible next cycle; reads return pre-write state with rd_valid one cycle later.
module trigger_csr_regs
    import trigger_csr_regs_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_TRIG   = 2
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    input  logic                  csr_wr_en,
    input  logic                  csr_rd_en,
    input  logic [11:0]           csr_addr,
    input  logic [DATA_WIDTH-1:0] csr_wr_data,
    output logic [DATA_WIDTH-1:0] csr_rd_data,
    output logic                  csr_rd_valid,
    output logic                  csr_ill,
    input  logic                  dbg_mode,
    input  logic [1:0]            trigger_hit,
    output logic                  tselect,
    output logic [DATA_WIDTH-1:0] tdata1,
    output logic [DATA_WIDTH-1:0] tdata2_t0,
    output logic [DATA_WIDTH-1:0] tdata2_t1,
    output logic [DATA_WIDTH-1:0] tdata3_t0,
    output logic [DATA_WIDTH-1:0] tdata3_t1
);

    logic                  tselect_q, tselect_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  ill_q, ill_d;

    logic                  in_page, unimpl;
    logic                  wr_t1, wr_t2, wr_t3;
    logic [1:0]            slot_ill;
    logic [31:0]           td1_0, td1_1;
    logic [DATA_WIDTH-1:0] rd_mux;

    assign in_page = csr_addr[11:4] == TRIG_PAGE;
    assign unimpl  = in_page && (csr_addr[3:0] > TINFO_ADDR[3:0]);
    assign wr_t1   = csr_wr_en && (csr_addr == TDATA1_ADDR);
    assign wr_t2   = csr_wr_en && (csr_addr == TDATA2_ADDR);
    assign wr_t3   = csr_wr_en && (csr_addr == TDATA3_ADDR);

    trigger_slot #(.DATA_WIDTH(DATA_WIDTH), .LAST(1'b0)) u_slot0 (
        .clk_i      (cpu_clk),
        .rst_i      (cpu_rst),
        .dbg_mode_i (dbg_mode),
        .wr1_en_i   (wr_t1 && !tselect_q),
        .wr2_en_i   (wr_t2 && !tselect_q),
        .wr3_en_i   (wr_t3 && !tselect_q),
        .wr_data_i  (csr_wr_data),
        .hw_hit_i   (trigger_hit[0]),
        .tdata1_o   (td1_0),
        .tdata2_o   (tdata2_t0),
        .tdata3_o   (tdata3_t0),
        .ill_o      (slot_ill[0])
    );

    trigger_slot #(.DATA_WIDTH(DATA_WIDTH), .LAST(1'b1)) u_slot1 (
        .clk_i      (cpu_clk),
        .rst_i      (cpu_rst),
        .dbg_mode_i (dbg_mode),
        .wr1_en_i   (wr_t1 && tselect_q),
        .wr2_en_i   (wr_t2 && tselect_q),
        .wr3_en_i   (wr_t3 && tselect_q),
        .wr_data_i  (csr_wr_data),
        .hw_hit_i   (trigger_hit[1]),
        .tdata1_o   (td1_1),
        .tdata2_o   (tdata2_t1),
        .tdata3_o   (tdata3_t1),
        .ill_o      (slot_ill[1])
    );

    assign tdata1 = tselect_q ? td1_1 : td1_0;

    always_comb begin
        tselect_d = tselect_q;
        if (csr_wr_en && (csr_addr == TSELECT_ADDR) &&
            (csr_wr_data < DATA_WIDTH'(NUM_TRIG))) begin
            tselect_d = csr_wr_data[0];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (csr_addr)
            TSELECT_ADDR: rd_mux = DATA_WIDTH'(tselect_q);
            TDATA1_ADDR:  rd_mux = tdata1;
            TDATA2_ADDR:  rd_mux = tselect_q ? tdata2_t1 : tdata2_t0;
            TDATA3_ADDR:  rd_mux = tselect_q ? tdata3_t1 : tdata3_t0;
            TINFO_ADDR:   rd_mux = TINFO_VAL;
            default:      rd_mux = '0;
        endcase
    end

    always_comb begin
        rd_valid_d = csr_rd_en && in_page;
        rd_data_d  = rd_valid_d ? rd_mux : '0;
        ill_d      = ((csr_rd_en || csr_wr_en) && unimpl) || (|slot_ill);
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            tselect_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ill_q      <= 1'b0;
        end else begin
            tselect_q  <= tselect_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ill_q      <= ill_d;
        end
    end

    assign tselect      = tselect_q;
    assign csr_rd_data  = rd_data_q;
    assign csr_rd_valid = rd_valid_q;
    assign csr_ill      = ill_q;

endmodule

// File: tb/tb_trigger_csr_regs.sv
// Directed bench for trigger_csr_regs with hand-computed expected values.
module tb_trigger_csr_regs;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        csr_wr_en, csr_rd_en;
    logic [11:0] csr_addr;
    logic [31:0] csr_wr_data, csr_rd_data;
    logic        csr_rd_valid, csr_ill;
    logic        dbg_mode;
    logic [1:0]  trigger_hit;
    logic        tselect;
    logic [31:0] tdata1, tdata2_t0, tdata2_t1, tdata3_t0, tdata3_t1;

    int total = 0;
    int bad   = 0;

    logic [31:0] rdat;
    logic        rval, rill, will;

    trigger_csr_regs #(.DATA_WIDTH(32), .NUM_TRIG(2)) dut (
        .cpu_clk      (cpu_clk),
        .cpu_rst      (cpu_rst),
        .csr_wr_en    (csr_wr_en),
        .csr_rd_en    (csr_rd_en),
        .csr_addr     (csr_addr),
        .csr_wr_data  (csr_wr_data),
        .csr_rd_data  (csr_rd_data),
        .csr_rd_valid (csr_rd_valid),
        .csr_ill      (csr_ill),
        .dbg_mode     (dbg_mode),
        .trigger_hit  (trigger_hit),
        .tselect      (tselect),
        .tdata1       (tdata1),
        .tdata2_t0    (tdata2_t0),
        .tdata2_t1    (tdata2_t1),
        .tdata3_t0    (tdata3_t0),
        .tdata3_t1    (tdata3_t1)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [1:0] h,
                      output logic ill);
        @(negedge cpu_clk);
        csr_wr_en = 1'b1; csr_addr = a; csr_wr_data = d; trigger_hit = h;
        @(negedge cpu_clk);
        csr_wr_en = 1'b0; trigger_hit = 2'b00;
        ill = csr_ill;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d, output logic v,
                      output logic il);
        @(negedge cpu_clk);
        csr_rd_en = 1'b1; csr_addr = a;
        @(negedge cpu_clk);
        csr_rd_en = 1'b0;
        d = csr_rd_data; v = csr_rd_valid; il = csr_ill;
    endtask

    initial begin
        cpu_rst = 1'b1; csr_wr_en = 1'b0; csr_rd_en = 1'b0; csr_addr = '0;
        csr_wr_data = '0; dbg_mode = 1'b0; trigger_hit = 2'b00;
        #12;
        chk("rst_tselect", {31'b0, tselect}, 32'h0);
        chk("rst_tdata1", tdata1, 32'h2000_0000);
        chk("rst_tdata2_t1", tdata2_t1, 32'h0);
        chk("rst_rd_valid", {31'b0, csr_rd_valid}, 32'h0);
        chk("rst_ill", {31'b0, csr_ill}, 32'h0);
        @(negedge cpu_clk);
        cpu_rst = 1'b0;

        rd(12'h7A1, rdat, rval, rill);
        chk("rd_tdata1", rdat, 32'h2000_0000);
        chk("rd_tdata1_vld", {31'b0, rval}, 32'h1);
        chk("rd_tdata1_ill", {31'b0, rill}, 32'h0);
        chk("rd_vld_drops", {31'b0, csr_rd_valid}, 32'h1);
        @(negedge cpu_clk);
        chk("rd_vld_pulse", {31'b0, csr_rd_valid}, 32'h0);
        rd(12'h7A2, rdat, rval, rill);
        chk("rd_tdata2", rdat, 32'h0);
        rd(12'h7A4, rdat, rval, rill);
        chk("rd_tinfo", rdat, 32'h4);

        // tselect WARL and per-trigger tdata2
        wr(12'h7A0, 32'h1, 2'b00, will);
        chk("tsel_1", {31'b0, tselect}, 32'h1);
        wr(12'h7A2, 32'h8000_0100, 2'b00, will);
        chk("t1_tdata2", tdata2_t1, 32'h8000_0100);
        chk("t0_tdata2_kept", tdata2_t0, 32'h0);
        wr(12'h7A0, 32'h5, 2'b00, will);
        chk("tsel_warl5", {31'b0, tselect}, 32'h1);
        wr(12'h7A0, 32'h2, 2'b00, will);
        chk("tsel_warl2", {31'b0, tselect}, 32'h1);
        rd(12'h7A0, rdat, rval, rill);
        chk("rd_tsel", rdat, 32'h1);
        wr(12'h7A3, 32'hCAFE_0003, 2'b00, will);
        chk("t1_tdata3", tdata3_t1, 32'hCAFE_0003);
        chk("t0_tdata3_kept", tdata3_t0, 32'h0);

        // tdata1 WARL legalisation on trigger 0
        wr(12'h7A0, 32'h0, 2'b00, will);
        chk("tsel_0", {31'b0, tselect}, 32'h0);
        wr(12'h7A1, 32'h2FFF_FFFF, 2'b00, will);
        chk("warl_all_ones", tdata1, 32'h2010_1847);
        rd(12'h7A1, rdat, rval, rill);
        chk("rd_warl", rdat, 32'h2010_1847);
        wr(12'h7A1, 32'h5000_0007, 2'b00, will);
        chk("warl_bad_type", tdata1, 32'h0);
        wr(12'h7A1, 32'h2000_2000, 2'b00, will);
        chk("warl_action2", tdata1, 32'h2000_0000);

        // dmode protection
        dbg_mode = 1'b1;
        wr(12'h7A1, 32'h2800_0044, 2'b00, will);
        chk("dmode_set", tdata1, 32'h2800_0044);
        chk("dmode_set_ill", {31'b0, will}, 32'h0);
        dbg_mode = 1'b0;
        wr(12'h7A2, 32'h0000_1234, 2'b00, will);
        chk("prot_ill", {31'b0, will}, 32'h1);
        chk("prot_tdata2", tdata2_t0, 32'h0);
        @(negedge cpu_clk);
        chk("prot_ill_pulse", {31'b0, csr_ill}, 32'h0);
        wr(12'h7A1, 32'h2000_0000, 2'b00, will);
        chk("prot_tdata1", tdata1, 32'h2800_0044);
        dbg_mode = 1'b1;
        wr(12'h7A1, 32'h2000_0000, 2'b00, will);
        chk("dmode_clear", tdata1, 32'h2000_0000);
        dbg_mode = 1'b0;

        // hardware hit, alone and against a software write
        wr(12'h7A3, 32'h0, 2'b01, will);
        chk("hw_hit_t0", tdata1, 32'h2010_0000);
        wr(12'h7A1, 32'h2000_0000, 2'b00, will);
        chk("sw_hit_clear", tdata1, 32'h2000_0000);
        wr(12'h7A0, 32'h1, 2'b00, will);
        wr(12'h7A1, 32'h2000_0800, 2'b00, will);
        chk("t1_chain_ro", tdata1, 32'h2000_0000);
        wr(12'h7A1, 32'h2000_0004, 2'b10, will);
        chk("hit_vs_write", tdata1, 32'h2010_0004);
        rd(12'h7A1, rdat, rval, rill);
        chk("rd_hit_vs_write", rdat, 32'h2010_0004);
        wr(12'h7A0, 32'h0, 2'b00, will);
        chk("t0_untouched", tdata1, 32'h2000_0000);

        // read and write same address in one cycle
        @(negedge cpu_clk);
        csr_rd_en = 1'b1; csr_wr_en = 1'b1; csr_addr = 12'h7A1; csr_wr_data = 32'h2000_0001;
        @(negedge cpu_clk);
        csr_rd_en = 1'b0; csr_wr_en = 1'b0;
        chk("rdwr_old", csr_rd_data, 32'h2000_0000);
        chk("rdwr_new", tdata1, 32'h2000_0001);

        // tinfo and unimplemented/out-of-range addresses
        wr(12'h7A4, 32'hFFFF_FFFF, 2'b00, will);
        chk("tinfo_wr_ill", {31'b0, will}, 32'h0);
        rd(12'h7A4, rdat, rval, rill);
        chk("tinfo_ro", rdat, 32'h4);
        rd(12'h7A8, rdat, rval, rill);
        chk("unimpl_data", rdat, 32'h0);
        chk("unimpl_vld", {31'b0, rval}, 32'h1);
        chk("unimpl_ill", {31'b0, rill}, 32'h1);
        rd(12'h7AF, rdat, rval, rill);
        chk("unimpl_top_ill", {31'b0, rill}, 32'h1);
        wr(12'h7A9, 32'h1, 2'b00, will);
        chk("unimpl_wr_ill", {31'b0, will}, 32'h1);
        rd(12'h300, rdat, rval, rill);
        chk("outside_vld", {31'b0, rval}, 32'h0);
        chk("outside_ill", {31'b0, rill}, 32'h0);

        // reset while a read is in flight
        wr(12'h7A0, 32'h1, 2'b00, will);
        @(negedge cpu_clk);
        csr_rd_en = 1'b1; csr_addr = 12'h7A1;
        #2 cpu_rst = 1'b1;
        @(posedge cpu_clk);
        #1;
        chk("rst_mid_vld", {31'b0, csr_rd_valid}, 32'h0);
        chk("rst_mid_tsel", {31'b0, tselect}, 32'h0);
        chk("rst_mid_tdata1", tdata1, 32'h2000_0000);
        chk("rst_mid_tdata3", tdata3_t1, 32'h0);
        csr_rd_en = 1'b0;
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        @(negedge cpu_clk);
        chk("post_rst_vld", {31'b0, csr_rd_valid}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
